// File: rtl/mem_initiator_if.sv
// mem_initiator_if: request/response and memory-strobe bundle for mem_initiator.
// The master side is the datapath plus Memory; the slave side is the initiator.
interface mem_initiator_if #(
    parameter int N = 32
) ();
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [N-1:0] req_addr;
    logic [N-1:0] req_wdata;
    logic         rsp_valid;
    logic [N-1:0] rsp_rdata;
    logic         rsp_err;
    logic         mem_ren;
    logic         mem_wen;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_din;
    logic [N-1:0] mem_dout;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_ren, mem_wen, mem_addr, mem_din
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_ren, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_initiator.sv
// mem_initiator: sequences Memory ren/wen with setup and hold around a WAIT-cycle strobe.
// Optional MEM_INIT_RANGE_CHECK_EN rejects addresses outside the low 1K words.
module mem_initiator #(
    parameter int N    = 32,
    parameter int WAIT = 1
) (
    input logic            clock,
    input logic            reset,
    mem_initiator_if.slave bus
);
`ifdef MEM_INIT_RANGE_CHECK_EN
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD} state_t;
`endif

    localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         we_q, we_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] din_q, din_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic         ren_q, ren_d;
    logic         wen_q, wen_d;
    logic         ready_q, ready_d;
    logic         rsp_valid_q, rsp_valid_d;
`ifdef MEM_INIT_RANGE_CHECK_EN
    logic         rsp_err_q, rsp_err_d;
`endif

    // Next-state and registered-output logic; strobes are set one edge early
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rdata_d     = rdata_q;
        ren_d       = 1'b0;
        wen_d       = 1'b0;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
`ifdef MEM_INIT_RANGE_CHECK_EN
        rsp_err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.req_valid && ready_q) begin
                    ready_d = 1'b0;
`ifdef MEM_INIT_RANGE_CHECK_EN
                    if (|bus.req_addr[N-1:10]) begin
                        state_d     = ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = SETUP;
                        we_d    = bus.req_we;
                        addr_d  = bus.req_addr;
                        din_d   = bus.req_wdata;
                    end
`else
                    state_d = SETUP;
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    din_d   = bus.req_wdata;
`endif
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_LOAD;
                ren_d   = !we_q;
                wen_d   = we_q;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d     = HOLD;
                    rsp_valid_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = bus.mem_dout;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    ren_d = !we_q;
                    wen_d = we_q;
                end
            end
            HOLD: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
`ifdef MEM_INIT_RANGE_CHECK_EN
            ERR: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops strobes without a clock
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rdata_q     <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
`ifdef MEM_INIT_RANGE_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rdata_q     <= rdata_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef MEM_INIT_RANGE_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_ren   = ren_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;
`ifdef MEM_INIT_RANGE_CHECK_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed scoreboard bench for mem_initiator at WAIT=1 and WAIT=3.
// Each DUT talks to its own word memory; expectations come from a separate reference array.
module tb_mem_initiator;
    logic clock;
    logic rst1, rst3;
    logic tb_init;
    int   cyc;
    int   sel;
    int   vectors;
    int   miscompares;

    mem_initiator_if #(.N(32)) b1 ();
    mem_initiator_if #(.N(32)) b3 ();

    mem_initiator #(.N(32), .WAIT(1)) dut1 (.clock(clock), .reset(rst1), .bus(b1));
    mem_initiator #(.N(32), .WAIT(3)) dut3 (.clock(clock), .reset(rst3), .bus(b3));

    logic [31:0] env1 [1024];
    logic [31:0] env3 [1024];
    logic [31:0] refm [2][1024];
    logic [31:0] exp_rd [2];
    logic [31:0] exp_addr [2];
    logic [31:0] exp_din [2];
    logic [32:0] sb [$];
    int          acc_cyc;

    function automatic logic [31:0] pat(input int i);
        return (i == 7) ? 32'h0000_1234 : (32'hC0DE_0000 | 32'(i));
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (tb_init) begin
            for (int i = 0; i < 1024; i++) env1[i] <= pat(i);
        end else if (b1.mem_wen) begin
            env1[b1.mem_addr[9:0]] <= b1.mem_din;
        end
    end

    always @(posedge clock) begin
        if (tb_init) begin
            for (int i = 0; i < 1024; i++) env3[i] <= pat(i);
        end else if (b3.mem_wen) begin
            env3[b3.mem_addr[9:0]] <= b3.mem_din;
        end
    end

    assign b1.mem_dout = env1[b1.mem_addr[9:0]];
    assign b3.mem_dout = env3[b3.mem_addr[9:0]];

    logic        s_ready, s_valid, s_err, s_ren, s_wen;
    logic [31:0] s_rdata, s_addr, s_din;
    assign s_ready = (sel == 1) ? b3.req_ready : b1.req_ready;
    assign s_valid = (sel == 1) ? b3.rsp_valid : b1.rsp_valid;
    assign s_err   = (sel == 1) ? b3.rsp_err   : b1.rsp_err;
    assign s_ren   = (sel == 1) ? b3.mem_ren   : b1.mem_ren;
    assign s_wen   = (sel == 1) ? b3.mem_wen   : b1.mem_wen;
    assign s_rdata = (sel == 1) ? b3.rsp_rdata : b1.rsp_rdata;
    assign s_addr  = (sel == 1) ? b3.mem_addr  : b1.mem_addr;
    assign s_din   = (sel == 1) ? b3.mem_din   : b1.mem_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s sel=%0d observed=%h expected=%h", tag, sel, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s sel=%0d observed=%b expected=%b", tag, sel, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (sel == 1) begin
            b3.req_valid = v; b3.req_we = we; b3.req_addr = a; b3.req_wdata = d;
        end else begin
            b1.req_valid = v; b1.req_we = we; b1.req_addr = a; b1.req_wdata = d;
        end
    endtask

    task automatic check_reset_vals();
        chk1("rst_ready", s_ready, 1'b1);
        chk1("rst_valid", s_valid, 1'b0);
        chk1("rst_err", s_err, 1'b0);
        chk1("rst_ren", s_ren, 1'b0);
        chk1("rst_wen", s_wen, 1'b0);
        chk("rst_rdata", s_rdata, 32'h0);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_din", s_din, 32'h0);
    endtask

    // Called at a negedge; returns at the negedge of the IDLE cycle that follows.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d, input bit keep);
        int w, last;
        bit err, strobe;
        logic [32:0] e;
        w = (sel == 1) ? 3 : 1;
        err = 1'b0;
`ifdef MEM_INIT_RANGE_CHECK_EN
        err = (a[31:10] != 22'd0);
`endif
        if (err) begin
            sb.push_back({1'b1, exp_rd[sel]});
        end else begin
            if (we) refm[sel][a[9:0]] = d;
            else exp_rd[sel] = refm[sel][a[9:0]];
            sb.push_back({1'b0, exp_rd[sel]});
            exp_addr[sel] = a;
            exp_din[sel]  = d;
        end
        drive(1'b1, we, a, d);
        chk1("acc_ready", s_ready, 1'b1);
        @(posedge clock);
        last = err ? 2 : 3 + w;
        for (int k = 1; k <= last; k++) begin
            @(negedge clock);
            if (k == 1) begin
                acc_cyc = cyc;
                if (!keep) drive(1'b0, 1'b0, 32'h0, 32'h0);
            end
            strobe = !err && k >= 2 && k <= 1 + w;
            chk1("mem_wen", s_wen, we && strobe);
            chk1("mem_ren", s_ren, !we && strobe);
            chk1("both_strobes", s_wen && s_ren, 1'b0);
            chk1("rsp_valid", s_valid, k == last - 1);
            chk1("req_ready", s_ready, k == last);
            chk("mem_addr", s_addr, exp_addr[sel]);
            chk("mem_din", s_din, exp_din[sel]);
            if (s_valid) begin
                if (sb.size() == 0) begin
                    chk1("sb_underflow", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk1("rsp_err", s_err, e[32]);
                    chk("rsp_rdata", s_rdata, e[31:0]);
                end
            end
        end
    endtask

    initial begin
        int a0, a1, a2;
        vectors = 0;
        miscompares = 0;
        sel = 0;
        cyc = 0;
        tb_init = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            refm[0][i] = pat(i);
            refm[1][i] = pat(i);
        end
        for (int s = 0; s < 2; s++) begin
            exp_rd[s] = 32'h0; exp_addr[s] = 32'h0; exp_din[s] = 32'h0;
        end
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
        b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_addr = '0; b3.req_wdata = '0;
        rst1 = 1'b1; rst3 = 1'b1;
        #1 rst1 = 1'b0; rst3 = 1'b0;
        repeat (3) @(negedge clock);
        tb_init = 1'b0;
        sel = 0; #0 check_reset_vals();
        sel = 1; #0 check_reset_vals();
        rst1 = 1'b1; rst3 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            sel = k % 2;
            #0;
            chk1("quiet_ready", s_ready, 1'b1);
            chk1("quiet_valid", s_valid, 1'b0);
            chk1("quiet_strobe", s_ren || s_wen, 1'b0);
        end

        sel = 0;
        @(negedge clock);
        access(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 32'd5, 32'h0, 1'b0);
        chk("load5_rdata", s_rdata, 32'hDEAD_BEEF);

        access(1'b0, 32'd7, 32'h0, 1'b0);
        access(1'b1, 32'd8, 32'h5555_AAAA, 1'b0);
        @(negedge clock);
        chk("rdata_held_after_store", s_rdata, 32'h0000_1234);

        access(1'b0, 32'h400, 32'h0, 1'b0);
        access(1'b0, 32'h3FF, 32'h0, 1'b0);
        chk1("err_after_3ff", s_err, 1'b0);

        sel = 1;
        @(negedge clock);
        access(1'b0, 32'd7, 32'h0, 1'b1);
        a0 = acc_cyc;
        access(1'b0, 32'd1, 32'h0, 1'b1);
        a1 = acc_cyc;
        access(1'b0, 32'd2, 32'h0, 1'b0);
        a2 = acc_cyc;
        chk("period_1", 32'(a1 - a0), 32'd6);
        chk("period_2", 32'(a2 - a1), 32'd6);

        @(negedge clock);
        drive(1'b1, 1'b1, 32'd20, 32'hCAFE_F00D);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        chk1("intr_wen_c2", s_wen, 1'b1);
        @(negedge clock);
        chk1("intr_wen_c3", s_wen, 1'b1);
        #2 rst3 = 1'b0;
        #1;
        chk1("intr_wen_async", s_wen, 1'b0);
        chk1("intr_ready_async", s_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk1("intr_no_valid", s_valid, 1'b0);
        end
        rst3 = 1'b1;
        exp_rd[1] = 32'h0; exp_addr[1] = 32'h0; exp_din[1] = 32'h0;
        @(negedge clock);
        check_reset_vals();
        access(1'b0, 32'd9, 32'h0, 1'b0);
        access(1'b1, 32'd30, 32'h0BAD_F00D, 1'b0);
        access(1'b0, 32'd30, 32'h0, 1'b0);
        chk("post_reset_load", s_rdata, 32'h0BAD_F00D);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
